// File: rtl/pio_debounced_irq.sv
// Avalon-MM parallel I/O: set/clear output port, debounced input port
// with per-bit rising/falling edge capture and a maskable level interrupt.
module pio_debounced_irq #(
   parameter int                   IN_WIDTH        = 4,
   parameter int                   OUT_WIDTH       = 8,
   parameter int                   DEBOUNCE_CYCLES = 50000,
   parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   input  logic [2:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   output logic                 avs_readdatavalid,
   output logic                 irq,
   input  logic [IN_WIDTH-1:0]  pi_export,
   output logic [OUT_WIDTH-1:0] po_export
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
   logic [IN_WIDTH-1:0]  deb_q, deb_d;
   logic [CW-1:0]        cnt_q [IN_WIDTH];
   logic [CW-1:0]        cnt_d [IN_WIDTH];
   logic [IN_WIDTH-1:0]  mask_q, mask_d;
   logic [IN_WIDTH-1:0]  rise_q, rise_d;
   logic [IN_WIDTH-1:0]  fall_q, fall_d;
   logic [IN_WIDTH-1:0]  edge_q, edge_d;
   logic [IN_WIDTH-1:0]  edge_clr;
   logic [IN_WIDTH-1:0]  cap;
   logic [OUT_WIDTH-1:0] out_q, out_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 rvalid_q;

   logic [IN_WIDTH-1:0]  wd_in;
   logic [OUT_WIDTH-1:0] wd_out;
   logic                 unused_wd;

   assign wd_in     = avs_writedata[IN_WIDTH-1:0];
   assign wd_out    = avs_writedata[OUT_WIDTH-1:0];
   assign unused_wd = ^avs_writedata;

   // A bit flips only after CNT_MAX+1 consecutive disagreeing samples
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < IN_WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign cap = (deb_d & ~deb_q & rise_q)
              | (~deb_d & deb_q & fall_q);

   always_comb begin
      out_d    = out_q;
      mask_d   = mask_q;
      rise_d   = rise_q;
      fall_d   = fall_q;
      edge_clr = '0;
      if (avs_write) begin
         unique case (avs_address)
            3'd0:    out_d    = wd_out;
            3'd2:    mask_d   = wd_in;
            3'd3:    edge_clr = wd_in;
            3'd4:    rise_d   = wd_in;
            3'd5:    fall_d   = wd_in;
            3'd6:    out_d    = out_q | wd_out;
            3'd7:    out_d    = out_q & ~wd_out;
            default: ;
         endcase
      end
   end

   // A capture on the same edge as a write-1-clear keeps the bit set
   assign edge_d = (edge_q & ~edge_clr) | cap;

   always_comb begin
      rdata_d = rdata_q;
      if (avs_read) begin
         rdata_d = '0;
         unique case (avs_address)
            3'd0:    rdata_d[IN_WIDTH-1:0]  = deb_q;
            3'd1:    rdata_d[OUT_WIDTH-1:0] = out_q;
            3'd2:    rdata_d[IN_WIDTH-1:0]  = mask_q;
            3'd3:    rdata_d[IN_WIDTH-1:0]  = edge_q;
            3'd4:    rdata_d[IN_WIDTH-1:0]  = rise_q;
            3'd5:    rdata_d[IN_WIDTH-1:0]  = fall_q;
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
         mask_q   <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         edge_q   <= '0;
         out_q    <= OUT_RESET;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         sync1_q  <= pi_export;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_d[i];
         mask_q   <= mask_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         edge_q   <= edge_d;
         out_q    <= out_d;
         rdata_q  <= rdata_d;
         rvalid_q <= avs_read;
      end
   end

   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;
   assign po_export         = out_q;
   assign irq               = |(edge_q & mask_q);

endmodule

// File: doc/pio_debounced_irq.md
# pio_debounced_irq

Parametrised Avalon-MM parallel I/O block that replaces the fixed LED/switch/key PIOs in the wallet SoC. It provides a configurable-width output port with atomic set/clear registers. It also provides a configurable-width input port with per-bit synchronisation, debouncing, selectable rising/falling edge capture and a maskable interrupt to the Nios II. One instance serves LEDs plus switches; another serves keys.

## Interface
- IN_WIDTH, 4, input port width (1–32)
- OUT_WIDTH, 8, output port width (1–32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept an input change (≥2)
- OUT_RESET, 0, reset value of output register (OUT_WIDTH bits)

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  asynchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe, single cycle
- avs_write  in  1  write strobe, single cycle
- avs_writedata  in  32  write data
- avs_readdata  out  32  registered read data
- avs_readdatavalid  out  1  high one cycle after avs_read
- irq  out  1  level interrupt, high while (EDGE & MASK) ≠ 0
- pi_export  in  IN_WIDTH  asynchronous external inputs (switches/keys)
- po_export  out  OUT_WIDTH  output register (LEDs)

## Operation
Register map (word addresses). Bits above the port width read 0 and ignore writes.
- 0 DATA: the read returns the debounced inputs; the write loads the output register.
- 1 OUT: the read returns the output register; writes are ignored.
- 2 MASK: R/W IRQ mask, IN_WIDTH bits.
- 3 EDGE: the read returns the edge-capture bits; the write is write-1-to-clear.
- 4 RISE_EN: R/W; enables rising-edge capture per bit.
- 5 FALL_EN: R/W; enables falling-edge capture per bit.
- 6 SET: the write ORs writedata into the output register; the read returns 0.
- 7 CLR: the write clears output bits where writedata is 1; the read returns 0.

Input path, applied per bit:
- Each bit passes through a 2-flop synchroniser to give sync[i].
- Each bit has a counter of width clog2(DEBOUNCE_CYCLES).
- While sync[i] ≠ deb[i], the counter increments. While sync[i] = deb[i], the counter is held at 0.
- On the edge where the counter equals DEBOUNCE_CYCLES−1 and sync[i] ≠ deb[i]:
  - deb[i] toggles and the counter returns to 0.
  - On that same edge, EDGE[i] is set if the new deb[i]=1 and RISE_EN[i]=1.
  - EDGE[i] is likewise set if the new deb[i]=0 and FALL_EN[i]=1.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles leaves deb unchanged and restarts the count.

Interrupt:
- irq is the combinational OR of (EDGE & MASK), taken from registers only.
- EDGE bits persist until cleared by software, independent of MASK.

## Timing
- Reset values:
  - po_export = OUT_RESET.
  - deb, counters, synchroniser flops, MASK, RISE_EN, FALL_EN and EDGE = 0.
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
- Writes take effect on the clock edge at which avs_write is sampled.
  - po_export changes on that edge, with zero wait states.
- Reads have a fixed latency of 1.
  - avs_readdata and avs_readdatavalid are registered on the edge after avs_read is sampled.
  - The value returned is the register state before that edge.
  - avs_readdata holds its value when no read is in progress.
- Pin-to-deb latency is 2 + DEBOUNCE_CYCLES cycles after a stable pin change.
  - EDGE sets on the same edge as deb changes.
  - irq rises combinationally after that edge.
- Simultaneous EDGE write-1-clear and new capture on the same bit: the capture wins and the bit stays 1.
- Clearing a MASK bit drops irq on the next edge if no other masked EDGE bit is set.
- A read of EDGE on the edge a capture occurs returns the old value; the new bit is visible on the next read.
- Reset asserted mid-operation clears everything immediately, asynchronously, including any debounce count in progress.
- After reset release with a pin held high, deb still starts at 0.
  - The pin is debounced to 1 after 2 + DEBOUNCE_CYCLES cycles.
  - A rising edge is captured only if RISE_EN was set by then.
- avs_read and avs_write are never asserted together. If they are, the write is performed and the read returns pre-write data.

## Test plan
Configuration for all scenarios: IN_WIDTH=4, OUT_WIDTH=8, DEBOUNCE_CYCLES=4, OUT_RESET=8'hA5.
- Reset and output registers:
  - Stimulus: assert reset_reset, release, read addr 1; then write 0x3C to addr 0, write 0x81 to SET, write 0x0C to CLR, read addr 1.
  - Required response: first read returns 0xA5, with po_export=0xA5 during reset. Sequence gives po_export 0x3C → 0xBD → 0xB1; final read returns 0x000000B1.
- Debounce acceptance and rejection:
  - Stimulus: pi_export[0] high for 3 cycles then low.
  - Required response: deb unchanged, DATA reads 0.
  - Stimulus: pi_export[0] held high.
  - Required response: DATA bit 0 reads 1 exactly 6 cycles after the pin rises.
- Edge capture and irq:
  - Stimulus: RISE_EN=0x1, FALL_EN=0x2, MASK=0x3; toggle bit1 0→1→0 with 10-cycle holds.
  - Required response: EDGE=0x2 only after the falling edge; irq=1.
  - Stimulus: write 0x2 to EDGE.
  - Required response: irq=0 next cycle.
- Clear/capture collision:
  - Stimulus: write 1 to EDGE[0] on the exact edge a new rising capture of bit 0 occurs.
  - Required response: EDGE[0] stays 1 and irq stays high.
- Mask gating:
  - Stimulus: EDGE=0x4 with MASK=0.
  - Required response: irq=0.
  - Stimulus: set MASK=0x4.
  - Required response: irq=1 after the write edge; EDGE unchanged.
- Reset mid-debounce:
  - Stimulus: assert reset 2 cycles into the count on bit 3, then release with the pin still high.
  - Required response: deb[3]=0 during reset; deb[3]=1 six cycles after release; no EDGE set, because RISE_EN reset to 0.
